rx_vector_assembler: RTL and testbench
======================================

// Module: rx_vector_assembler
//
// PURPOSE
// Sits between the data-UART byte receiver and the GDP controller. It frames the
// incoming byte stream into one feature vector: N_RX_NUMS signed 16-bit values.
// Each frame is started by the new_vector_incoming pin from L'Imperatrice. A
// completed vector is presented on rx_nums with a one-cycle rx_available strobe,
// which feeds new_vector_available. The block detects aborted, restarted and
// overrun frames.
//
// PARAMETERS
// N_RX_NUMS       3      number of 16-bit values per vector (1..255)
// TIMEOUT_CYCLES  50000  max clk cycles between bytes inside a frame (1 ms @ 50 MHz)
//
// PORTS
// clk                  in   1            50 MHz system clock
// reset                in   1            asynchronous, active-high reset
// byte_valid           in   1            1-cycle strobe: byte_data holds a received byte
// byte_data            in   8            received UART byte
// new_vector_incoming  in   1            async level from ARM; a rising edge starts a frame
// gdp_idle             in   1            GDP controller idle (overrun check only)
// rx_nums              out  N_RX_NUMS*16 committed vector, type num [N_RX_NUMS-1:0]
// rx_available         out  1            1-cycle strobe: rx_nums just updated
// busy                 out  1            frame in progress (state != WAIT_SYNC)
// frame_error          out  1            1-cycle strobe: frame aborted (timeout or restart)
// overrun              out  1            sticky: vector committed while gdp_idle was low
//
// BEHAVIOUR
// - Reset values: rx_nums all 16'h0000; rx_available, busy, frame_error and overrun
//   all 0; state WAIT_SYNC; shadow registers 0; counters 0.
// - new_vector_incoming passes through a 2-flop synchroniser, then a rising-edge
//   detector. The internal start pulse occurs 3 clk after the pin edge. A held-high
//   level does not retrigger.
// - Byte order is big-endian per value: the high byte comes first.
//   Word w = {hi, lo}, stored as signed 16-bit with no sign manipulation.
//   Words arrive in index order 0..N_RX_NUMS-1 and go into shadow[w].
// - Word counter: $clog2(N_RX_NUMS)+1 bits, cleared on every start.
// - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits. It clears on every start and
//   on every accepted byte, and saturates (never wraps).
// - States:
//   - WAIT_SYNC: byte_valid is ignored. On start, go to RX_HI.
//   - RX_HI: on byte_valid, latch the hi byte and go to RX_LO.
//   - RX_LO: on byte_valid, write {hi, byte_data} to shadow[w].
//     If w == N_RX_NUMS-1, go to COMMIT; otherwise increment w and go to RX_HI.
//   - COMMIT: lasts exactly 1 cycle, then returns to WAIT_SYNC.
//     rx_nums <= shadow, and rx_available = 1 in the following cycle, aligned with
//     the new rx_nums. If gdp_idle == 0 during COMMIT, set overrun.
// - Latency: rx_available rises 2 clk after the byte_valid of the final lo byte.
// - rx_nums holds its value until the next COMMIT. Aborted frames never modify it.
// - Timeout: in RX_HI or RX_LO, if the counter reaches TIMEOUT_CYCLES, pulse
//   frame_error and go to WAIT_SYNC. Partial shadow contents are discarded.
// - Restart: a start pulse while in RX_HI or RX_LO pulses frame_error, then goes
//   to RX_HI with w = 0 and the counters cleared.
// - Simultaneous events:
//   - start and byte_valid in the same cycle: start wins and the byte is dropped.
//   - timeout and byte_valid in the same cycle: the byte is accepted and there is
//     no timeout.
//   - start during COMMIT: the commit completes, then the state is RX_HI.
// - Reset mid-frame: the block returns immediately to reset values. A partial
//   frame is lost. overrun is cleared only by reset.
// - busy = 1 in RX_HI, RX_LO and COMMIT.
//
// TESTING
// 1. N=3. Pin rises, then bytes F6 A5 FE DA FD 3C with gdp_idle=1
//    -> rx_nums = {FD3C, FEDA, F6A5}; rx_available high exactly 1 cycle,
//       2 clk after the last byte; overrun = 0.
// 2. Send 3 bytes, then stay idle TIMEOUT_CYCLES clk -> frame_error pulses once;
//    busy = 0; rx_nums unchanged from test 1.
// 3. Pin rises after 4 bytes, then 6 fresh bytes 00 01 00 02 00 03
//    -> one frame_error; rx_nums = {0003, 0002, 0001}.
// 4. Complete a frame with gdp_idle=0 -> overrun = 1 and stays 1 across a
//    following good frame; reset clears it.
// 5. byte_valid asserted in the same cycle as the internal start pulse
//    -> that byte is dropped and the next byte is taken as word 0 hi.
// 6. Assert reset during RX_LO of word 1 -> all outputs return to 0 immediately;
//    bytes without a new pin edge are ignored.

Source files
------------

// File: rtl/rx_vector_assembler.sv
// Frames the UART byte stream into one vector of N_RX_NUMS signed 16-bit words,
// started by a rising edge on new_vector_incoming; flags timeouts, restarts and overruns.
module rx_vector_assembler #(
  parameter int N_RX_NUMS      = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  input  logic                      new_vector_incoming,
  input  logic                      gdp_idle,
  output logic [N_RX_NUMS*16-1:0]   rx_nums,
  output logic                      rx_available,
  output logic                      busy,
  output logic                      frame_error,
  output logic                      overrun
);

  localparam int WORD_W = $clog2(N_RX_NUMS) + 1;
  localparam int IDX_W  = (N_RX_NUMS > 1) ? $clog2(N_RX_NUMS) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_RX_NUMS - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RX_HI     = 2'd1,
    RX_LO     = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t                         state_r;
  logic                           sync1_r;
  logic                           sync2_r;
  logic                           sync3_r;
  logic                           start_s;
  logic [7:0]                     hi_r;
  logic [WORD_W-1:0]              word_cnt_r;
  logic [TMO_W-1:0]               tmo_cnt_r;
  logic [N_RX_NUMS-1:0][15:0]     shadow_r;

  // sync2_r/sync3_r are the last two synchronised samples, so start is a clean one-cycle pulse
  assign start_s = sync2_r & ~sync3_r;

  // Synchroniser, framing FSM, shadow capture and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      sync3_r      <= 1'b0;
      state_r      <= WAIT_SYNC;
      hi_r         <= 8'h00;
      word_cnt_r   <= '0;
      tmo_cnt_r    <= '0;
      shadow_r     <= '0;
      rx_nums      <= '0;
      rx_available <= 1'b0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync1_r      <= new_vector_incoming;
      sync2_r      <= sync1_r;
      sync3_r      <= sync2_r;
      rx_available <= 1'b0;
      frame_error  <= 1'b0;
      case (state_r)
        WAIT_SYNC: begin
          if (start_s) begin
            state_r    <= RX_HI;
            busy       <= 1'b1;
            word_cnt_r <= '0;
            tmo_cnt_r  <= '0;
          end
        end
        RX_HI, RX_LO: begin
          if (start_s) begin
            frame_error <= 1'b1;
            state_r     <= RX_HI;
            busy        <= 1'b1;
            word_cnt_r  <= '0;
            tmo_cnt_r   <= '0;
          end else if (byte_valid) begin
            // an accepted byte always beats a timeout landing in the same cycle
            tmo_cnt_r <= '0;
            if (state_r == RX_HI) begin
              hi_r    <= byte_data;
              state_r <= RX_LO;
            end else begin
              shadow_r[word_cnt_r[IDX_W-1:0]] <= {hi_r, byte_data};
              if (word_cnt_r == LAST_WORD) begin
                state_r <= COMMIT;
              end else begin
                word_cnt_r <= word_cnt_r + WORD_W'(1);
                state_r    <= RX_HI;
              end
            end
          end else if (tmo_cnt_r == TMO_LIMIT) begin
            frame_error <= 1'b1;
            state_r     <= WAIT_SYNC;
            busy        <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        COMMIT: begin
          rx_nums      <= shadow_r;
          rx_available <= 1'b1;
          if (!gdp_idle) begin
            overrun <= 1'b1;
          end
          if (start_s) begin
            state_r    <= RX_HI;
            busy       <= 1'b1;
            word_cnt_r <= '0;
            tmo_cnt_r  <= '0;
          end else begin
            state_r <= WAIT_SYNC;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= WAIT_SYNC;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_vector_assembler.sv
// Randomised and directed bench for rx_vector_assembler, checked against a
// byte-list reference model that rebuilds each vector arithmetically.
module tb_rx_vector_assembler;

  localparam int N   = 3;
  localparam int TMO = 40;

  logic            clk;
  logic            reset;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            vec_pin;
  logic            gdp_idle;
  logic [N*16-1:0] rx_nums;
  logic            rx_available;
  logic            busy;
  logic            frame_error;
  logic            overrun;

  int n_cmp = 0;
  int n_err = 0;
  int avail_cnt = 0;
  int ferr_cnt  = 0;
  int exp_avail = 0;
  int exp_ferr  = 0;
  logic [N*16-1:0] exp_nums;
  logic            exp_ovr;
  logic [7:0]      frame_bytes [0:2*N-1];

  rx_vector_assembler #(.N_RX_NUMS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .byte_valid          (byte_valid),
    .byte_data           (byte_data),
    .new_vector_incoming (vec_pin),
    .gdp_idle            (gdp_idle),
    .rx_nums             (rx_nums),
    .rx_available        (rx_available),
    .busy                (busy),
    .frame_error         (frame_error),
    .overrun             (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe counters sampled on the falling edge
  always @(negedge clk) begin
    if (rx_available) avail_cnt <= avail_cnt + 1;
    if (frame_error)  ferr_cnt  <= ferr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    vec_pin = 1'b0;
    tick(3);
    vec_pin = 1'b1;
    tick(3);
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = frame_bytes[i];
      tick(1);
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      if (i < n - 1) tick($urandom_range(0, 3));
    end
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 2*N; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  // Called right after the final lo byte was clocked in
  task automatic check_commit(input string tag);
    for (int w = 0; w < N; w++)
      exp_nums[16*w +: 16] = 16'(frame_bytes[2*w]) * 16'd256 + 16'(frame_bytes[2*w+1]);
    if (!gdp_idle) exp_ovr = 1'b1;
    exp_avail++;
    check_eq({tag, "_avail_early"}, 64'(rx_available), 64'd0);
    tick(1);
    check_eq({tag, "_avail"}, 64'(rx_available), 64'd1);
    check_eq({tag, "_nums"}, 64'(rx_nums), 64'(exp_nums));
    check_eq({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
    tick(1);
    check_eq({tag, "_avail_off"}, 64'(rx_available), 64'd0);
    check_eq({tag, "_busy_off"}, 64'(busy), 64'd0);
    check_eq({tag, "_avail_cnt"}, 64'(avail_cnt), 64'(exp_avail));
    check_eq({tag, "_ferr_cnt"}, 64'(ferr_cnt), 64'(exp_ferr));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_nums"}, 64'(rx_nums), 64'd0);
    check_eq({tag, "_avail"}, 64'(rx_available), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_ferr"}, 64'(frame_error), 64'd0);
    check_eq({tag, "_ovr"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; vec_pin = 1'b0; gdp_idle = 1'b1;
    exp_nums = '0; exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_values("reset");
    tick(2);

    // 1: basic frame
    start_frame();
    check_eq("t1_busy", 64'(busy), 64'd1);
    frame_bytes = '{8'hF6, 8'hA5, 8'hFE, 8'hDA, 8'hFD, 8'h3C};
    send_bytes(6);
    check_commit("t1");
    check_eq("t1_value", 64'(rx_nums), 64'h0000_FD3C_FEDA_F6A5);

    // 2: timeout after a partial frame
    start_frame();
    rand_bytes();
    send_bytes(3);
    tick(TMO - 2);
    check_eq("t2_no_early_err", 64'(ferr_cnt), 64'(exp_ferr));
    check_eq("t2_busy_wait", 64'(busy), 64'd1);
    tick(6);
    exp_ferr++;
    check_eq("t2_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check_eq("t2_busy", 64'(busy), 64'd0);
    check_eq("t2_nums", 64'(rx_nums), 64'(exp_nums));

    // 3: restart after 4 bytes
    start_frame();
    rand_bytes();
    send_bytes(4);
    start_frame();
    exp_ferr++;
    frame_bytes = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_bytes(6);
    check_commit("t3");

    // 4: overrun is sticky until reset
    gdp_idle = 1'b0;
    start_frame();
    rand_bytes();
    send_bytes(6);
    check_commit("t4a");
    gdp_idle = 1'b1;
    start_frame();
    rand_bytes();
    send_bytes(6);
    check_commit("t4b");
    vec_pin = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("t4_reset");
    tick(1);
    reset = 1'b0;
    exp_nums = '0; exp_ovr = 1'b0;
    tick(3);

    // 5: byte coincident with the start pulse mid-frame is dropped
    start_frame();
    rand_bytes();
    send_bytes(2);
    vec_pin = 1'b0;
    tick(3);
    vec_pin = 1'b1;
    tick(2);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    tick(1);
    byte_valid = 1'b0;
    exp_ferr++;
    rand_bytes();
    send_bytes(6);
    check_commit("t5");

    // 6: reset in RX_LO of word 1, then bytes without a pin edge
    start_frame();
    rand_bytes();
    send_bytes(3);
    vec_pin = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("t6_reset");
    tick(1);
    reset = 1'b0;
    exp_nums = '0; exp_ovr = 1'b0;
    tick(2);
    rand_bytes();
    send_bytes(6);
    tick(3);
    check_eq("t6_avail_cnt", 64'(avail_cnt), 64'(exp_avail));
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_nums", 64'(rx_nums), 64'd0);

    // random mix of good, timed-out and restarted frames
    for (int it = 0; it < 20; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      gdp_idle = ($urandom_range(0, 3) != 0);
      start_frame();
      if (kind == 1) begin
        rand_bytes();
        send_bytes($urandom_range(1, 2*N - 1));
        tick(TMO + 6);
        exp_ferr++;
        check_eq("rnd_timeout_ferr", 64'(ferr_cnt), 64'(exp_ferr));
        check_eq("rnd_timeout_nums", 64'(rx_nums), 64'(exp_nums));
      end else begin
        if (kind == 2) begin
          rand_bytes();
          send_bytes($urandom_range(1, 2*N - 1));
          start_frame();
          exp_ferr++;
        end
        rand_bytes();
        send_bytes(2*N);
        check_commit("rnd");
      end
    end

    check_eq("final_avail_cnt", 64'(avail_cnt), 64'(exp_avail));
    check_eq("final_ferr_cnt", 64'(ferr_cnt), 64'(exp_ferr));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
